// File: rtl/gpu_task_dispatcher.sv
// Task packet parser between the scheduler message stream and the core array.
// Routes r0 and instruction words to cores with per-core strobes, tracks core
// busy state, and applies mask-collision and acquire/release fences.
module gpu_task_dispatcher #(
    parameter int unsigned CORE_NUM   = 16,
    parameter int unsigned BUS_WIDTH  = 16,
    parameter int unsigned FRAME_SIZE = 16,
    parameter int unsigned IFNUM_W    = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 msg_valid,
    input  logic [BUS_WIDTH-1:0] msg_data,
    output logic                 msg_ready,
    input  logic [CORE_NUM-1:0]  core_done,
    output logic [CORE_NUM-1:0]  core_ready,
    output logic [BUS_WIDTH-1:0] core_wdata,
    output logic [CORE_NUM-1:0]  core_r0_we,
    output logic [CORE_NUM-1:0]  core_if_we,
    output logic [CORE_NUM-1:0]  core_start,
    output logic                 fence_stall
);

    localparam int unsigned FS_W  = $clog2(FRAME_SIZE);
    localparam int unsigned CNT_W = IFNUM_W + FS_W;

    localparam logic [1:0] FENCE_ACQ = 2'd1;
    localparam logic [1:0] FENCE_REL = 2'd2;

    typedef enum logic [2:0] {
        S_HDR,
        S_MASK,
        S_R0M,
        S_CHECK,
        S_R0,
        S_INSTR,
        S_START,
        S_REL_WAIT
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            fence_q, fence_d;
    logic [IFNUM_W-1:0]    if_num_q, if_num_d;
    logic [CORE_NUM-1:0]   exec_q, exec_d;
    logic [CORE_NUM-1:0]   r0_rem_q, r0_rem_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CORE_NUM-1:0]   busy_q, busy_d;
    logic                  msg_ready_q, msg_ready_d;
    logic                  fence_stall_q, fence_stall_d;
    logic [BUS_WIDTH-1:0]  wdata_q, wdata_d;
    logic [CORE_NUM-1:0]   r0_we_q, r0_we_d;
    logic [CORE_NUM-1:0]   if_we_q, if_we_d;
    logic [CORE_NUM-1:0]   start_q, start_d;

    logic                  accept;
    logic [CORE_NUM-1:0]   busy_nd;
    logic [CORE_NUM-1:0]   r0_low;
    logic [CORE_NUM-1:0]   r0_rem_nx;
    logic [CNT_W-1:0]      instr_last;
    logic                  blocked;
    logic                  blocked_nx;

    // Handshake, post-done busy view, lowest pending r0 target, last instr index
    assign accept     = msg_valid && msg_ready_q;
    assign busy_nd    = busy_q & ~core_done;
    assign r0_low     = r0_rem_q & (~r0_rem_q + CORE_NUM'(1));
    assign r0_rem_nx  = r0_rem_q & ~r0_low;
    assign instr_last = {if_num_q, FS_W'(0)} - CNT_W'(1);
    assign blocked    = (exec_q != '0) &&
                        (((exec_q & busy_nd) != '0) ||
                         ((fence_q == FENCE_ACQ) && (busy_nd != '0)));

    // Packet parser: next state, captured fields, strobes and busy tracking
    always_comb begin
        state_d       = state_q;
        fence_d       = fence_q;
        if_num_d      = if_num_q;
        exec_d        = exec_q;
        r0_rem_d      = r0_rem_q;
        cnt_d         = cnt_q;
        busy_d        = busy_nd;
        wdata_d       = wdata_q;
        r0_we_d       = '0;
        if_we_d       = '0;
        start_d       = '0;
        msg_ready_d   = 1'b0;
        fence_stall_d = 1'b0;
        blocked_nx    = 1'b0;

        if (accept) begin
            wdata_d = msg_data;
        end

        case (state_q)
            S_HDR: begin
                if (accept) begin
                    fence_d  = msg_data[IFNUM_W+1:IFNUM_W];
                    if_num_d = msg_data[IFNUM_W-1:0];
                    state_d  = S_MASK;
                end
            end
            S_MASK: begin
                if (accept) begin
                    exec_d  = CORE_NUM'(msg_data);
                    state_d = S_R0M;
                end
            end
            S_R0M: begin
                if (accept) begin
                    r0_rem_d = CORE_NUM'(msg_data) & exec_q;
                    cnt_d    = '0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!blocked) begin
                    if (r0_rem_q != '0) begin
                        state_d = S_R0;
                    end else if (if_num_q != '0) begin
                        state_d = S_INSTR;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_R0: begin
                if (accept) begin
                    r0_we_d  = r0_low;
                    r0_rem_d = r0_rem_nx;
                    if (r0_rem_nx == '0) begin
                        state_d = (if_num_q != '0) ? S_INSTR : S_START;
                    end
                end
            end
            S_INSTR: begin
                if (accept) begin
                    if_we_d = exec_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == instr_last) begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                start_d = exec_q;
                busy_d  = busy_nd | exec_q;
                state_d = ((fence_q == FENCE_REL) && (exec_q != '0)) ? S_REL_WAIT : S_HDR;
            end
            S_REL_WAIT: begin
                if ((exec_q & busy_nd) == '0) begin
                    state_d = S_HDR;
                end
            end
            default: begin
                state_d = S_HDR;
            end
        endcase

        blocked_nx    = (exec_d != '0) &&
                        (((exec_d & busy_d) != '0) ||
                         ((fence_d == FENCE_ACQ) && (busy_d != '0)));
        msg_ready_d   = (state_d == S_HDR) || (state_d == S_MASK) || (state_d == S_R0M) ||
                        (state_d == S_R0)  || (state_d == S_INSTR);
        fence_stall_d = ((state_d == S_CHECK) && blocked_nx) || (state_d == S_REL_WAIT);
    end

    // State and output registers; synchronous reset discards any partial packet
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_HDR;
            fence_q       <= '0;
            if_num_q      <= '0;
            exec_q        <= '0;
            r0_rem_q      <= '0;
            cnt_q         <= '0;
            busy_q        <= '0;
            msg_ready_q   <= 1'b0;
            fence_stall_q <= 1'b0;
            wdata_q       <= '0;
            r0_we_q       <= '0;
            if_we_q       <= '0;
            start_q       <= '0;
        end else begin
            state_q       <= state_d;
            fence_q       <= fence_d;
            if_num_q      <= if_num_d;
            exec_q        <= exec_d;
            r0_rem_q      <= r0_rem_d;
            cnt_q         <= cnt_d;
            busy_q        <= busy_d;
            msg_ready_q   <= msg_ready_d;
            fence_stall_q <= fence_stall_d;
            wdata_q       <= wdata_d;
            r0_we_q       <= r0_we_d;
            if_we_q       <= if_we_d;
            start_q       <= start_d;
        end
    end

    assign msg_ready   = msg_ready_q;
    assign fence_stall = fence_stall_q;
    assign core_ready  = ~busy_q;
    assign core_wdata  = wdata_q;
    assign core_r0_we  = r0_we_q;
    assign core_if_we  = if_we_q;
    assign core_start  = start_q;

endmodule

// File: tb/tb_gpu_task_dispatcher.sv
// Self-checking bench for gpu_task_dispatcher: table of packets, directed
// fence/collision/reset sequences, and random packets against an event model.
module tb_gpu_task_dispatcher;

    logic        clk;
    logic        reset;
    logic        msg_valid;
    logic [15:0] msg_data;
    logic        msg_ready;
    logic [15:0] core_done;
    logic [15:0] core_ready;
    logic [15:0] core_wdata;
    logic [15:0] core_r0_we;
    logic [15:0] core_if_we;
    logic [15:0] core_start;
    logic        fence_stall;

    gpu_task_dispatcher dut (
        .clk        (clk),
        .reset      (reset),
        .msg_valid  (msg_valid),
        .msg_data   (msg_data),
        .msg_ready  (msg_ready),
        .core_done  (core_done),
        .core_ready (core_ready),
        .core_wdata (core_wdata),
        .core_r0_we (core_r0_we),
        .core_if_we (core_if_we),
        .core_start (core_start),
        .fence_stall(fence_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    localparam logic [1:0] EV_R0 = 2'd0;
    localparam logic [1:0] EV_IF = 2'd1;
    localparam logic [1:0] EV_ST = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] mask;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        logic [15:0] hdr;
        logic [15:0] exec;
        logic [15:0] r0m;
        int          exp_r0;
        int          exp_if;
        logic [15:0] exp_start;
        logic [15:0] exp_r0sum;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   r0_cnt = 0;
    int   if_cnt = 0;
    int   r0_sum = 0;
    int   start_sum = 0;
    logic chk_en = 1'b0;
    ev_t  exp_q[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endfunction

    function automatic void cmp_ev(input logic [1:0] k, input logic [15:0] m, input logic [15:0] d);
        ev_t e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_event: got kind=%0d mask=%h data=%h, required none", k, m, d);
        end else begin
            e = exp_q.pop_front();
            chk("ev_kind", 32'(k), 32'(e.kind));
            chk("ev_mask", 32'(m), 32'(e.mask));
            if (k != EV_ST) chk("ev_data", 32'(d), 32'(e.data));
        end
    endfunction

    // Output monitor: running strobe statistics plus in-order event scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (core_r0_we != 16'h0) begin
                r0_cnt++;
                r0_sum += int'(core_r0_we);
            end
            if (core_if_we != 16'h0) if_cnt++;
            if (core_start != 16'h0) start_sum += int'(core_start);
            if (chk_en) begin
                if (core_r0_we != 16'h0) cmp_ev(EV_R0, core_r0_we, core_wdata);
                if (core_if_we != 16'h0) cmp_ev(EV_IF, core_if_we, core_wdata);
                if (core_start != 16'h0) cmp_ev(EV_ST, core_start, 16'h0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input int gap);
        int n;
        msg_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        msg_valid = 1'b1;
        msg_data  = w;
        n = 0;
        while (msg_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
        end
        @(posedge clk);
        #1 msg_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [15:0] hdr, input logic [15:0] ex, input logic [15:0] rm);
        int nr0;
        int nins;
        nr0  = $countones(rm & ex);
        nins = int'(hdr[5:0]) * 16;
        send_word(hdr, 0);
        send_word(ex, 0);
        send_word(rm, 0);
        for (int k = 0; k < nr0; k++) send_word(16'hA000 + 16'(k), 0);
        for (int k = 0; k < nins; k++) send_word(16'h1000 + 16'(k), 0);
    endtask

    task automatic pulse_done(input logic [15:0] m);
        @(negedge clk);
        core_done = m;
        @(negedge clk);
        core_done = 16'h0;
    endtask

    vec_t        tbl[5];
    int          s_r0, s_if, s_r0sum, s_st;
    logic [15:0] exp_rdy;

    initial begin
        tbl[0] = '{16'h0001, 16'h0003, 16'h0002, 1, 16, 16'h0003, 16'h0002};
        tbl[1] = '{16'h0000, 16'h8001, 16'hFFFF, 2,  0, 16'h8001, 16'h8001};
        tbl[2] = '{16'h0002, 16'h00F0, 16'h0F0F, 0, 32, 16'h00F0, 16'h0000};
        tbl[3] = '{16'h00C1, 16'hFFFF, 16'h0005, 2, 16, 16'hFFFF, 16'h0005};
        tbl[4] = '{16'h0001, 16'h0000, 16'hFFFF, 0,  0, 16'h0000, 16'h0000};

        reset     = 1'b1;
        msg_valid = 1'b0;
        msg_data  = 16'h0;
        core_done = 16'h0;

        // Reset state
        wait_cycles(3);
        chk("rst_ready", 32'(core_ready), 32'hFFFF);
        chk("rst_r0we", 32'(core_r0_we), 32'h0);
        chk("rst_ifwe", 32'(core_if_we), 32'h0);
        chk("rst_start", 32'(core_start), 32'h0);
        chk("rst_wdata", 32'(core_wdata), 32'h0);
        chk("rst_msg_ready", 32'(msg_ready), 32'h0);
        chk("rst_stall", 32'(fence_stall), 32'h0);
        reset = 1'b0;
        wait_cycles(1);
        chk("post_rst_msg_ready", 32'(msg_ready), 32'h1);

        // Table-driven packets (T1, fence 3, zero r0_eff, zero exec T5)
        for (int i = 0; i < 5; i++) begin
            s_r0 = r0_cnt; s_if = if_cnt; s_r0sum = r0_sum; s_st = start_sum;
            send_pkt(tbl[i].hdr, tbl[i].exec, tbl[i].r0m);
            wait_cycles(4);
            chk("tbl_r0_count", 32'(r0_cnt - s_r0), 32'(tbl[i].exp_r0));
            chk("tbl_if_count", 32'(if_cnt - s_if), 32'(tbl[i].exp_if));
            chk("tbl_r0_targets", 32'(r0_sum - s_r0sum), 32'(tbl[i].exp_r0sum));
            chk("tbl_start", 32'(start_sum - s_st), 32'(tbl[i].exp_start));
            exp_rdy = ~tbl[i].exp_start;
            chk("tbl_core_ready", 32'(core_ready), 32'(exp_rdy));
            chk("tbl_msg_ready_idle", 32'(msg_ready), 32'h1);
            pulse_done(16'hFFFF);
            chk("tbl_ready_clr", 32'(core_ready), 32'hFFFF);
        end

        // T2: collision with busy core 1
        send_pkt(16'h0000, 16'h0002, 16'h0000);
        wait_cycles(4);
        chk("t2_busy", 32'(core_ready), 32'hFFFD);
        s_if = if_cnt; s_st = start_sum;
        send_word(16'h0001, 0);
        send_word(16'h0002, 0);
        send_word(16'h0000, 0);
        wait_cycles(4);
        chk("t2_stall_ready", 32'(msg_ready), 32'h0);
        chk("t2_stall_flag", 32'(fence_stall), 32'h1);
        pulse_done(16'h0002);
        chk("t2_resume_ready", 32'(msg_ready), 32'h1);
        chk("t2_resume_flag", 32'(fence_stall), 32'h0);
        for (int k = 0; k < 16; k++) send_word(16'h2000 + 16'(k), 0);
        wait_cycles(4);
        chk("t2_if_count", 32'(if_cnt - s_if), 32'd16);
        chk("t2_start", 32'(start_sum - s_st), 32'h0002);
        pulse_done(16'hFFFF);

        // T3: acquire fence waits on an unrelated busy core
        send_pkt(16'h0000, 16'h0020, 16'h0000);
        wait_cycles(4);
        s_if = if_cnt; s_st = start_sum;
        send_word(16'h0041, 0);
        send_word(16'h0001, 0);
        send_word(16'h0000, 0);
        wait_cycles(4);
        chk("t3_stall_ready", 32'(msg_ready), 32'h0);
        chk("t3_stall_flag", 32'(fence_stall), 32'h1);
        pulse_done(16'h0020);
        chk("t3_resume_ready", 32'(msg_ready), 32'h1);
        for (int k = 0; k < 16; k++) send_word(16'h3000 + 16'(k), 1);
        wait_cycles(4);
        chk("t3_if_count", 32'(if_cnt - s_if), 32'd16);
        chk("t3_start", 32'(start_sum - s_st), 32'h0001);
        pulse_done(16'hFFFF);

        // T4: release fence holds off the next header
        s_r0 = r0_cnt; s_st = start_sum;
        send_pkt(16'h0080, 16'h0010, 16'h0010);
        msg_valid = 1'b1;
        msg_data  = 16'h0000;
        wait_cycles(4);
        chk("t4_start", 32'(start_sum - s_st), 32'h0010);
        chk("t4_r0_count", 32'(r0_cnt - s_r0), 32'd1);
        chk("t4_hold_ready", 32'(msg_ready), 32'h0);
        chk("t4_hold_flag", 32'(fence_stall), 32'h1);
        chk("t4_busy", 32'(core_ready), 32'hFFEF);
        pulse_done(16'h0010);
        chk("t4_release_ready", 32'(msg_ready), 32'h1);
        chk("t4_release_flag", 32'(fence_stall), 32'h0);
        @(posedge clk);
        #1 msg_valid = 1'b0;
        send_word(16'h0000, 0);
        send_word(16'h0000, 0);
        wait_cycles(3);
        chk("t4_idle_ready", 32'(msg_ready), 32'h1);

        // Randomized packets against the event model
        chk_en = 1'b1;
        for (int p = 0; p < 30; p++) begin
            logic [15:0] hdr;
            logic [15:0] ex;
            logic [15:0] rm;
            logic [15:0] eff;
            logic [15:0] w;
            logic [15:0] wq[$];
            int          nins;
            int          n;
            hdr = {8'h00, ($urandom_range(0, 1) != 0) ? 2'd3 : 2'd0, 6'($urandom_range(0, 2))};
            ex  = 16'($urandom);
            if ($urandom_range(0, 4) == 0) ex = 16'h0;
            rm  = 16'($urandom);
            eff = rm & ex;
            wq.delete();
            wq.push_back(hdr);
            wq.push_back(ex);
            wq.push_back(rm);
            for (int c = 0; c < 16; c++) begin
                if (eff[c]) begin
                    w = 16'($urandom);
                    wq.push_back(w);
                    exp_q.push_back('{EV_R0, 16'(1) << c, w});
                end
            end
            nins = int'(hdr[5:0]) * 16;
            for (int k = 0; k < nins; k++) begin
                w = 16'($urandom);
                wq.push_back(w);
                if (ex != 16'h0) exp_q.push_back('{EV_IF, ex, w});
            end
            if (ex != 16'h0) exp_q.push_back('{EV_ST, ex, 16'h0});
            foreach (wq[k]) send_word(wq[k], $urandom_range(0, 2));
            n = 0;
            while (exp_q.size() != 0 && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (exp_q.size() != 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rnd_missing_events: %0d events outstanding, required 0", exp_q.size());
                exp_q.delete();
            end
            wait_cycles(1);
            exp_rdy = ~ex;
            chk("rnd_core_ready", 32'(core_ready), 32'(exp_rdy));
            pulse_done(16'hFFFF);
            chk("rnd_ready_clr", 32'(core_ready), 32'hFFFF);
        end
        chk_en = 1'b0;
        wait_cycles(2);

        // T6: reset mid-INSTR with a busy core
        send_pkt(16'h0000, 16'h0100, 16'h0000);
        wait_cycles(4);
        send_word(16'h0001, 0);
        send_word(16'h0001, 0);
        send_word(16'h0001, 0);
        send_word(16'hA5A5, 0);
        for (int k = 0; k < 5; k++) send_word(16'h1234 + 16'(k), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_wdata", 32'(core_wdata), 32'h0);
        chk("t6_r0we", 32'(core_r0_we), 32'h0);
        chk("t6_ifwe", 32'(core_if_we), 32'h0);
        chk("t6_start", 32'(core_start), 32'h0);
        chk("t6_ready", 32'(core_ready), 32'hFFFF);
        chk("t6_msg_ready", 32'(msg_ready), 32'h0);
        reset = 1'b0;
        wait_cycles(1);
        chk("t6_msg_ready_back", 32'(msg_ready), 32'h1);
        s_r0 = r0_cnt; s_if = if_cnt; s_r0sum = r0_sum; s_st = start_sum;
        send_pkt(16'h0001, 16'h0003, 16'h0002);
        wait_cycles(4);
        chk("t6_r0_count", 32'(r0_cnt - s_r0), 32'd1);
        chk("t6_r0_target", 32'(r0_sum - s_r0sum), 32'h0002);
        chk("t6_if_count", 32'(if_cnt - s_if), 32'd16);
        chk("t6_pkt_start", 32'(start_sum - s_st), 32'h0003);
        chk("t6_pkt_ready", 32'(core_ready), 32'hFFFC);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
